// File: rtl/fp_mult_rr_scheduler.sv
// Round-robin share of one FP multiplier among NUM_REQ lanes. Grant, issue and LATENCY=0 results are combinational.
// Results return LATENCY cycles after issue. There is no response backpressure, and a lane waits at most NUM_REQ-1 issues.
module fp_mult_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 0,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   mul_go,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [31:0]            mul_res,
  input  logic                   mul_exc,
  input  logic                   mul_ovf,
  input  logic                   mul_unf,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [31:0]            rsp_res,
  output logic [2:0]             rsp_flags,
  output logic [3:0]             in_flight,
  output logic                   idle
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_id;
  logic           grant_vld;

  // Walk from the farthest candidate back to ptr+1 so the nearest valid lane is the last (winning) assignment.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx] && !reset) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  assign mul_go = grant_vld;
  assign mul_a  = grant_vld ? req_a[32*grant_id +: 32] : 32'h0;
  assign mul_b  = grant_vld ? req_b[32*grant_id +: 32] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IDW'(NUM_REQ - 1);
    end else if (grant_vld) begin
      ptr <= grant_id;
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign rsp_valid = mul_go;
      assign rsp_id    = grant_id;
      assign in_flight = 4'd0;
    end else begin : g_pipe
      logic [LATENCY-1:0] tag_v;
      logic [IDW-1:0]     tag_id [LATENCY];

      always_ff @(posedge clk) begin
        if (reset) begin
          tag_v <= '0;
        end else begin
          tag_v[0]  <= mul_go;
          tag_id[0] <= grant_id;
          for (int i = 1; i < LATENCY; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
          end
        end
      end

      always_comb begin
        in_flight = 4'd0;
        for (int i = 0; i < LATENCY; i++) begin
          in_flight = in_flight + 4'(tag_v[i]);
        end
      end

      assign rsp_valid = tag_v[LATENCY-1];
      assign rsp_id    = tag_id[LATENCY-1];
    end
  endgenerate

  // The multiplier's outputs are only meaningful alongside a live tag.
  assign rsp_res   = rsp_valid ? mul_res : 32'h0;
  assign rsp_flags = rsp_valid ? {mul_exc, mul_ovf, mul_unf} : 3'b000;
  assign idle      = (in_flight == 4'd0) && !(|req_valid);

endmodule

// File: tb/tb_fp_mult_rr_scheduler.sv
// Directed bench: three scheduler instances (LATENCY 0, 2, 3) with stub multipliers for known operand pairs.
module tb_fp_mult_rr_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = 4'b0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Returns {exc, ovf, unf, res}; other operand pairs yield a ^ b so the lanes stay distinguishable.
  function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return {3'b000, 32'h40C0_0000};
    if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return {3'b000, 32'h4010_0000};
    if (a == 32'h7F80_0000) return {3'b100, 32'h0000_0000};
    if (a == 32'h7F00_0000 && b == 32'h7F00_0000) return {3'b010, 32'h7F80_0000};
    return {3'b000, a ^ b};
  endfunction

  // LATENCY = 0 instance
  logic [3:0]  rdy0; logic go0; logic [31:0] a0, b0, res0; logic exc0, ovf0, unf0;
  logic rv0; logic [1:0] rid0; logic [31:0] rres0; logic [2:0] rfl0; logic [3:0] inf0; logic idle0;
  assign {exc0, ovf0, unf0, res0} = fmul(a0, b0);

  fp_mult_rr_scheduler #(.NUM_REQ(4), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rdy0), .mul_go(go0), .mul_a(a0), .mul_b(b0),
    .mul_res(res0), .mul_exc(exc0), .mul_ovf(ovf0), .mul_unf(unf0),
    .rsp_valid(rv0), .rsp_id(rid0), .rsp_res(rres0), .rsp_flags(rfl0),
    .in_flight(inf0), .idle(idle0));

  // LATENCY = 2 instance
  logic [3:0]  rdy2; logic go2; logic [31:0] a2, b2, res2; logic exc2, ovf2, unf2;
  logic rv2; logic [1:0] rid2; logic [31:0] rres2; logic [2:0] rfl2; logic [3:0] inf2; logic idle2;
  logic [34:0] p2 [2];
  always @(posedge clk) begin
    p2[0] <= fmul(a2, b2);
    p2[1] <= p2[0];
  end
  assign {exc2, ovf2, unf2, res2} = p2[1];

  fp_mult_rr_scheduler #(.NUM_REQ(4), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rdy2), .mul_go(go2), .mul_a(a2), .mul_b(b2),
    .mul_res(res2), .mul_exc(exc2), .mul_ovf(ovf2), .mul_unf(unf2),
    .rsp_valid(rv2), .rsp_id(rid2), .rsp_res(rres2), .rsp_flags(rfl2),
    .in_flight(inf2), .idle(idle2));

  // LATENCY = 3 instance; its stub is never reset, so stale results keep arriving after a reset
  logic [3:0]  rdy3; logic go3; logic [31:0] a3, b3, res3; logic exc3, ovf3, unf3;
  logic rv3; logic [1:0] rid3; logic [31:0] rres3; logic [2:0] rfl3; logic [3:0] inf3; logic idle3;
  logic [34:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= fmul(a3, b3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {exc3, ovf3, unf3, res3} = p3[2];

  fp_mult_rr_scheduler #(.NUM_REQ(4), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rdy3), .mul_go(go3), .mul_a(a3), .mul_b(b3),
    .mul_res(res3), .mul_exc(exc3), .mul_ovf(ovf3), .mul_unf(unf3),
    .rsp_valid(rv3), .rsp_id(rid3), .rsp_res(rres3), .rsp_flags(rfl3),
    .in_flight(inf3), .idle(idle3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 4'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b1111;
    tick();
    @(negedge clk);
    checks++; if (rdy2 !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", rdy2); end
    checks++; if (go2 !== 1'b0) begin errors++; $display("FAIL reset_go got %b exp 0", go2); end
    checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rv2); end
    checks++; if (rv0 !== 1'b0 || rdy0 !== 4'b0000) begin errors++; $display("FAIL reset_l0 got rv=%b rdy=%b exp 0 0000", rv0, rdy0); end
    checks++; if (inf2 !== 4'd0) begin errors++; $display("FAIL reset_in_flight got %0d exp 0", inf2); end
    tick();
    reset = 1'b0;
    req_valid = 4'b0;
    @(negedge clk);
    checks++; if (idle2 !== 1'b1 || go2 !== 1'b0) begin errors++; $display("FAIL reset_idle got idle=%b go=%b exp 1 0", idle2, go2); end
    tick();
  endtask

  task automatic test_comb();
    do_reset();
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4040_0000;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (rdy0 !== 4'b0001) begin errors++; $display("FAIL comb_ready got %b exp 0001", rdy0); end
    checks++; if (go0 !== 1'b1 || a0 !== 32'h4000_0000 || b0 !== 32'h4040_0000) begin errors++; $display("FAIL comb_issue got go=%b a=%h b=%h exp 1 40000000 40400000", go0, a0, b0); end
    checks++; if (rv0 !== 1'b1 || rid0 !== 2'd0) begin errors++; $display("FAIL comb_rsp got v=%b id=%0d exp 1 0", rv0, rid0); end
    checks++; if (rres0 !== 32'h40C0_0000 || rfl0 !== 3'b000) begin errors++; $display("FAIL comb_res got %h fl=%b exp 40c00000 000", rres0, rfl0); end
    checks++; if (inf0 !== 4'd0) begin errors++; $display("FAIL comb_in_flight got %0d exp 0", inf0); end
    tick();
    req_a[127:96] = 32'h1234_5678;
    req_b[127:96] = 32'h0F0F_0000;
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (rdy0 !== 4'b1000 || rid0 !== 2'd3 || rres0 !== 32'h1D3B_5678) begin errors++; $display("FAIL comb_lane3 got rdy=%b id=%0d res=%h exp 1000 3 1d3b5678", rdy0, rid0, rres0); end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rv0 !== 1'b0 || rres0 !== 32'h0 || a0 !== 32'h0 || go0 !== 1'b0) begin errors++; $display("FAIL comb_none got v=%b res=%h a=%h go=%b exp 0 0 0 0", rv0, rres0, a0, go0); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] la [4];
    logic [31:0] lb [4];
    int exp_inf;
    logic [34:0] exp_r;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      la[i] = 32'hA000_0000 | 32'(i);
      lb[i] = 32'h0000_0B00 | 32'(i << 4);
      req_a[32*i +: 32] = la[i];
      req_b[32*i +: 32] = lb[i];
    end
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      if (c < 8) begin
        checks++; if (rdy2 !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_grant c=%0d got %b exp %b", c, rdy2, 4'(1 << (c % 4))); end
        checks++; if (a2 !== la[c % 4] || b2 !== lb[c % 4]) begin errors++; $display("FAIL rr_operands c=%0d got %h %h exp %h %h", c, a2, b2, la[c % 4], lb[c % 4]); end
      end
      if (c >= 2 && c <= 9) begin
        exp_r = fmul(la[(c - 2) % 4], lb[(c - 2) % 4]);
        checks++; if (rv2 !== 1'b1 || rid2 !== 2'((c - 2) % 4) || rres2 !== exp_r[31:0]) begin errors++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d res=%h exp 1 %0d %h", c, rv2, rid2, rres2, (c - 2) % 4, exp_r[31:0]); end
      end else begin
        checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL rr_rsp_idle c=%0d got %b exp 0", c, rv2); end
      end
      exp_inf = ((c - 1 >= 0 && c - 1 <= 7) ? 1 : 0) + ((c - 2 >= 0 && c - 2 <= 7) ? 1 : 0);
      checks++; if (inf2 !== 4'(exp_inf)) begin errors++; $display("FAIL rr_in_flight c=%0d got %0d exp %0d", c, inf2, exp_inf); end
      tick();
    end
    @(negedge clk);
    checks++; if (idle2 !== 1'b1) begin errors++; $display("FAIL rr_idle_end got %b exp 1", idle2); end
    tick();
  endtask

  task automatic test_tag_order();
    do_reset();
    req_a[95:64] = 32'h3FC0_0000; req_b[95:64] = 32'h3FC0_0000;
    req_a[63:32] = 32'h4000_0000; req_b[63:32] = 32'h4040_0000;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (rdy2 !== 4'b0100) begin errors++; $display("FAIL tag_grant_t got %b exp 0100", rdy2); end
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (rdy2 !== 4'b0010) begin errors++; $display("FAIL tag_grant_t1 got %b exp 0010", rdy2); end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rv2 !== 1'b1 || rid2 !== 2'd2 || rres2 !== 32'h4010_0000 || rfl2 !== 3'b000) begin errors++; $display("FAIL tag_rsp_t2 got v=%b id=%0d res=%h fl=%b exp 1 2 40100000 000", rv2, rid2, rres2, rfl2); end
    tick();
    @(negedge clk);
    checks++; if (rv2 !== 1'b1 || rid2 !== 2'd1 || rres2 !== 32'h40C0_0000) begin errors++; $display("FAIL tag_rsp_t3 got v=%b id=%0d res=%h exp 1 1 40c00000", rv2, rid2, rres2); end
    tick();
    @(negedge clk);
    checks++; if (rv2 !== 1'b0 || rres2 !== 32'h0 || rfl2 !== 3'b000) begin errors++; $display("FAIL tag_rsp_t4 got v=%b res=%h fl=%b exp 0 0 000", rv2, rres2, rfl2); end
    tick();
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 0) ? 4'b1000 : 4'b1001;
      @(negedge clk);
      checks++; if (rdy2 !== exp_seq[c]) begin errors++; $display("FAIL wrap_grant c=%0d got %b exp %b", c, rdy2, exp_seq[c]); end
      tick();
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_flags();
    do_reset();
    req_a[31:0] = 32'h7F80_0000; req_b[31:0] = 32'h3F80_0000;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (rdy2 !== 4'b0001) begin errors++; $display("FAIL flags_grant0 got %b exp 0001", rdy2); end
    tick();
    req_a[31:0] = 32'h7F00_0000; req_b[31:0] = 32'h7F00_0000;
    @(negedge clk);
    checks++; if (rdy2 !== 4'b0001 || a2 !== 32'h7F00_0000) begin errors++; $display("FAIL flags_back_to_back got rdy=%b a=%h exp 0001 7f000000", rdy2, a2); end
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rv2 !== 1'b1 || rfl2 !== 3'b100 || rres2 !== 32'h0) begin errors++; $display("FAIL flags_exc got v=%b fl=%b res=%h exp 1 100 0", rv2, rfl2, rres2); end
    checks++; if (inf2 !== 4'd2) begin errors++; $display("FAIL flags_in_flight got %0d exp 2", inf2); end
    tick();
    @(negedge clk);
    checks++; if (rv2 !== 1'b1 || rfl2 !== 3'b010 || rres2 !== 32'h7F80_0000) begin errors++; $display("FAIL flags_ovf got v=%b fl=%b res=%h exp 1 010 7f800000", rv2, rfl2, rres2); end
    tick();
  endtask

  task automatic test_reset_flush();
    do_reset();
    req_a[31:0] = 32'h0000_1111; req_b[31:0] = 32'h2222_0000;
    req_a[63:32] = 32'h0000_3333; req_b[63:32] = 32'h4444_0000;
    req_valid = 4'b0011;
    @(negedge clk);
    checks++; if (rdy3 !== 4'b0001) begin errors++; $display("FAIL flush_issue0 got %b exp 0001", rdy3); end
    tick();
    @(negedge clk);
    checks++; if (rdy3 !== 4'b0010) begin errors++; $display("FAIL flush_issue1 got %b exp 0010", rdy3); end
    tick();
    req_valid = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (inf3 !== 4'd2) begin errors++; $display("FAIL flush_pre_reset got %0d exp 2", inf3); end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (rv3 !== 1'b0 || rres3 !== 32'h0 || inf3 !== 4'd0) begin errors++; $display("FAIL flush_quiet c=%0d got v=%b res=%h inf=%0d exp 0 0 0", c, rv3, rres3, inf3); end
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++; if (rdy3 !== 4'b0001) begin errors++; $display("FAIL flush_next_grant got %b exp 0001", rdy3); end
    tick();
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_comb();
    test_round_robin();
    test_tag_order();
    test_ptr_wrap();
    test_flags();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
